dmem_port_arbiter: RTL and testbench
====================================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 10, data-memory word address width; DATA_W, 32, data word width; MAX_BURST, 8, maximum DMA beats per tenure; STARVE_LIM, 4, consecutive DMA-blocked cycles before DMA is forced in.
REQ-002 Ports (name, direction, width, meaning):
- clk, input, 1, clock.
- reset, input, 1, synchronous active-low reset.
- cpu_req, input, 1, CPU load/store request.
- cpu_we, input, 1, CPU write enable.
- cpu_addr, input, ADDR_W, CPU word address.
- cpu_wdata, input, DATA_W, CPU store data.
- cpu_gnt, output, 1, CPU beat accepted this cycle.
- cpu_rvalid, output, 1, CPU read data valid.
- cpu_rdata, output, DATA_W, CPU read data.
- dma_req, dma_we, dma_last, input, 1 each, DMA/debug-loader request, write enable and final beat.
- dma_addr, input, ADDR_W, DMA word address.
- dma_wdata, input, DATA_W, DMA write data.
- dma_gnt, dma_rvalid, output, 1 each, DMA beat accepted and DMA read data valid.
- dma_rdata, output, DATA_W, DMA read data.
- mem_en, mem_we, output, 1 each, single-port memory enable and write enable.
- mem_addr, output, ADDR_W, memory word address.
- mem_wdata, output, DATA_W, memory write data.
- mem_rdata, input, DATA_W, memory read data, valid one cycle after a read enable.
- cpu_stall_cnt, output, 16, saturating count of cycles with cpu_req high and cpu_gnt low.

Function
REQ-003 At most one of cpu_gnt and dma_gnt SHALL be high in any cycle.
REQ-004 Grants SHALL be combinational from the current state and requests. mem_en/mem_we/mem_addr/mem_wdata SHALL be driven from the granted requester in the same cycle. mem_en SHALL be 0 when neither requester is granted.
REQ-005 The FSM states SHALL be IDLE, CPU_OWN and DMA_OWN.
REQ-006 In IDLE and CPU_OWN, cpu_req SHALL win unless starve_cnt equals STARVE_LIM. In that case DMA SHALL be granted and the state SHALL move to DMA_OWN.
REQ-007 In IDLE and CPU_OWN, dma_req with cpu_req low SHALL be granted and the state SHALL move to DMA_OWN.
REQ-008 starve_cnt SHALL increment each cycle dma_req is high and dma_gnt is low. It SHALL clear on any dma_gnt.
REQ-009 In DMA_OWN, DMA SHALL keep the port while dma_req is high. cpu_gnt SHALL stay 0.
REQ-010 A granted beat with dma_last=1 SHALL end the tenure; the next state SHALL be IDLE. So SHALL the MAX_BURST-th granted beat of the tenure.
REQ-011 If dma_req drops in DMA_OWN, no grant SHALL issue that cycle and the state SHALL return to IDLE.
REQ-012 The burst counter SHALL count granted DMA beats in the current tenure. It SHALL clear on leaving DMA_OWN.
REQ-013 A granted read (we=0) SHALL raise the owner's rvalid exactly one cycle later, with rdata = mem_rdata. A registered owner tag SHALL route the data, independent of the current grant.
REQ-014 rvalid SHALL stay low for writes. cpu_rdata and dma_rdata SHALL be 0 when their rvalid is low.
REQ-015 cpu_stall_cnt SHALL saturate at 16'hFFFF.
REQ-016 When cpu_req and dma_req rise together in IDLE with starve_cnt=0, CPU SHALL win.

Reset
REQ-017 On clk rising edge with reset=0, the following SHALL clear: state to IDLE, starve_cnt, burst counter, read-tag pipeline, cpu_stall_cnt.
REQ-018 During reset, all gnt, rvalid and mem_en outputs SHALL be 0.
REQ-019 A read in flight when reset asserts SHALL NOT produce rvalid after reset.

Structure
REQ-020 The state encoding and the owner-tag constants (NONE, CPU, DMA) SHALL live in the shared mini_mips_pkg package.
REQ-021 One sub-module, dmem_arb_fsm, SHALL hold the state, starve and burst counters. Muxing and the read pipeline SHALL stay in the top.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- CPU-only read: cpu_req=1, cpu_addr=5, mem[5]=32'hDEADBEEF -> cpu_gnt same cycle; cpu_rvalid and cpu_rdata=DEADBEEF next cycle.
- Simultaneous requests from IDLE: CPU write and DMA request -> CPU granted first, DMA granted the cycle after cpu_req drops.
- Starvation: cpu_req held high, dma_req held high -> dma_gnt on the 5th cycle (STARVE_LIM=4); cpu_stall_cnt increments during the DMA tenure.
- DMA burst of 8 writes with dma_last low -> exactly 8 dma_gnt, then state IDLE; a pending CPU request is granted on the next cycle.
- DMA read with dma_last=1 on the first beat -> one beat, dma_rvalid next cycle, tenure ends.
- Reset asserted the cycle after a CPU read grant -> no cpu_rvalid; all counters read 0 after reset deasserts.

Source files
------------

// File: rtl/mini_mips_pkg.sv
// rtl/mini_mips_pkg.sv - shared types for the mini_mips data-memory port arbiter
//
// Purpose: arbiter state encoding, read-owner tag constants and the helper
// that picks which requester a granted read belongs to.
// Ports: none (package).

package mini_mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    DMA_OWN = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } owner_e;

  // Owner of the read issued this cycle; writes and idle cycles return NONE.
  function automatic owner_e read_owner(
    input logic cpu_gnt,
    input logic cpu_we,
    input logic dma_gnt,
    input logic dma_we
  );
    if (cpu_gnt && !cpu_we) begin
      return CPU;
    end else if (dma_gnt && !dma_we) begin
      return DMA;
    end
    return NONE;
  endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// rtl/dmem_arb_fsm.sv - ownership FSM with starvation and burst counters
//
// Purpose: decides each cycle whether the CPU or the DMA/debug loader owns
// the single data-memory port. The CPU normally wins; a DMA requester that
// has been blocked STARVE_LIM cycles is forced in, and a DMA tenure ends on
// dma_last, on the MAX_BURST-th beat, or when dma_req drops.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   cpu_req_i       CPU request
//   dma_req_i       DMA request
//   dma_last_i      DMA final beat of the tenure
//   cpu_gnt_o       CPU beat accepted (combinational)
//   dma_gnt_o       DMA beat accepted (combinational)

module dmem_arb_fsm
  import mini_mips_pkg::*;
#(
  parameter int MAX_BURST  = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic dma_last_i,
  output logic cpu_gnt_o,
  output logic dma_gnt_o
);

  localparam int STARVE_W = $clog2(STARVE_LIM + 1);
  localparam int BURST_W  = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q;
  logic [BURST_W-1:0]  burst_q;

  logic force_dma;
  logic tenure_end;
  logic cpu_gnt, dma_gnt;

  // A blocked DMA that has waited long enough overrides the CPU.
  assign force_dma  = dma_req_i && (starve_q == STARVE_W'(STARVE_LIM));
  // burst_q counts beats already granted, so the MAX_BURST-th beat is the
  // one seen while burst_q holds MAX_BURST-1.
  assign tenure_end = dma_last_i || (burst_q == BURST_W'(MAX_BURST - 1));

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE, CPU_OWN: begin
        if (force_dma || (dma_req_i && !cpu_req_i)) begin
          dma_gnt = 1'b1;
          state_d = tenure_end ? IDLE : DMA_OWN;
        end else if (cpu_req_i) begin
          cpu_gnt = 1'b1;
          state_d = CPU_OWN;
        end else begin
          state_d = IDLE;
        end
      end
      DMA_OWN: begin
        if (dma_req_i) begin
          dma_gnt = 1'b1;
          state_d = tenure_end ? IDLE : DMA_OWN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // No grant may escape while the block is held in reset.
    if (!reset) begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end
  end

  assign cpu_gnt_o = cpu_gnt;
  assign dma_gnt_o = dma_gnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q <= state_d;

      if (dma_gnt) begin
        starve_q <= '0;
      end else if (dma_req_i && (starve_q != STARVE_W'(STARVE_LIM))) begin
        starve_q <= starve_q + 1'b1;
      end

      if (state_d != DMA_OWN) begin
        burst_q <= '0;
      end else if (dma_gnt) begin
        burst_q <= burst_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - CPU/DMA arbiter for a single-port data memory
//
// Purpose: shares one single-port data memory between the CPU load/store
// unit and the DMA/debug loader. Ownership comes from dmem_arb_fsm; this
// level muxes the granted requester onto the memory port, routes read data
// back one cycle later through a registered owner tag, and counts CPU stall
// cycles.
// Ports:
//   clk, reset                         clock, synchronous active-low reset
//   cpu_req/we/addr/wdata              CPU request side
//   cpu_gnt, cpu_rvalid, cpu_rdata     CPU response side
//   dma_req/we/last/addr/wdata         DMA request side
//   dma_gnt, dma_rvalid, dma_rdata     DMA response side
//   mem_en/we/addr/wdata, mem_rdata    memory port (read data one cycle late)
//   cpu_stall_cnt                      saturating CPU stall-cycle count

module dmem_port_arbiter
  import mini_mips_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_last,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       cpu_stall_cnt
);

  owner_e      rd_tag_q, rd_tag_d;
  logic [15:0] stall_q;

  dmem_arb_fsm #(
    .MAX_BURST (MAX_BURST),
    .STARVE_LIM(STARVE_LIM)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .cpu_req_i (cpu_req),
    .dma_req_i (dma_req),
    .dma_last_i(dma_last),
    .cpu_gnt_o (cpu_gnt),
    .dma_gnt_o (dma_gnt)
  );

  // Memory port follows the granted requester in the same cycle.
  always_comb begin
    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // The tag remembers who issued last cycle's read, so returning data goes
  // to its owner even if the port has since changed hands.
  assign rd_tag_d = read_owner(cpu_gnt, cpu_we, dma_gnt, dma_we);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_tag_q <= NONE;
      stall_q  <= '0;
    end else begin
      rd_tag_q <= rd_tag_d;
      if (cpu_req && !cpu_gnt && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  // Gating with reset hides a tag captured just before reset asserted.
  assign cpu_rvalid    = reset && (rd_tag_q == CPU);
  assign dma_rvalid    = reset && (rd_tag_q == DMA);
  assign cpu_rdata     = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata     = dma_rvalid ? mem_rdata : '0;
  assign cpu_stall_cnt = stall_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter

module tb_dmem_port_arbiter;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int MAX_BURST  = 8;
  localparam int STARVE_LIM = 4;

  logic              clk;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req, dma_we, dma_last;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       cpu_stall_cnt;

  logic              load_mem;
  logic [DATA_W-1:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST),
    .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_gnt      (cpu_gnt),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_last     (dma_last),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_gnt      (dma_gnt),
    .dma_rvalid   (dma_rvalid),
    .dma_rdata    (dma_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .cpu_stall_cnt(cpu_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
  endfunction

  // Single-port memory: read data appears the cycle after a read enable.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= mem_init(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: who may use the port this cycle, from the rules.
  int          m_own;     // 0 = port free / CPU, 2 = DMA tenure open
  int          m_wait;    // cycles DMA has been left waiting
  int          m_beats;   // DMA beats granted in the open tenure
  int          m_pend;    // 0 none, 1 CPU, 2 DMA read awaiting data
  logic [31:0] m_pend_data;
  logic [15:0] m_stall;
  logic [31:0] model_mem [0:1023];

  always @(negedge clk) begin
    bit ec, ed;
    ec = 1'b0;
    ed = 1'b0;
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) model_mem[i] = mem_init(i);
    end
    if (!reset) begin
      chk("m_rst_cpu_gnt", 32'(cpu_gnt), 0);
      chk("m_rst_dma_gnt", 32'(dma_gnt), 0);
      chk("m_rst_mem_en", 32'(mem_en), 0);
      chk("m_rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      chk("m_rst_dma_rvalid", 32'(dma_rvalid), 0);
      m_own = 0; m_wait = 0; m_beats = 0; m_pend = 0; m_stall = 16'd0;
    end else begin
      if (m_own == 2)                                        ed = dma_req;
      else if (dma_req && (m_wait == STARVE_LIM || !cpu_req)) ed = 1'b1;
      else                                                   ec = cpu_req;

      chk("m_cpu_gnt", 32'(cpu_gnt), 32'(ec));
      chk("m_dma_gnt", 32'(dma_gnt), 32'(ed));
      chk("m_mem_en", 32'(mem_en), 32'(ec | ed));
      if (ec) begin
        chk("m_mem_we", 32'(mem_we), 32'(cpu_we));
        chk("m_mem_addr", 32'(mem_addr), 32'(cpu_addr));
        chk("m_mem_wdata", mem_wdata, cpu_wdata);
      end else if (ed) begin
        chk("m_mem_we", 32'(mem_we), 32'(dma_we));
        chk("m_mem_addr", 32'(mem_addr), 32'(dma_addr));
        chk("m_mem_wdata", mem_wdata, dma_wdata);
      end
      chk("m_cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend == 1));
      chk("m_cpu_rdata", cpu_rdata, (m_pend == 1) ? m_pend_data : 32'd0);
      chk("m_dma_rvalid", 32'(dma_rvalid), 32'(m_pend == 2));
      chk("m_dma_rdata", dma_rdata, (m_pend == 2) ? m_pend_data : 32'd0);
      chk("m_stall_cnt", 32'(cpu_stall_cnt), 32'(m_stall));

      m_pend = 0;
      if (ec) begin
        if (cpu_we) model_mem[cpu_addr] = cpu_wdata;
        else begin m_pend = 1; m_pend_data = model_mem[cpu_addr]; end
      end
      if (ed) begin
        if (dma_we) model_mem[dma_addr] = dma_wdata;
        else begin m_pend = 2; m_pend_data = model_mem[dma_addr]; end
        m_beats++;
        m_wait = 0;
        if (dma_last || m_beats == MAX_BURST) begin m_own = 0; m_beats = 0; end
        else m_own = 2;
      end else begin
        if (m_own == 2) begin m_own = 0; m_beats = 0; end
        if (dma_req && m_wait < STARVE_LIM) m_wait++;
      end
      if (cpu_req && !ec && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    end
  end

  task automatic set_cpu(input bit r, input bit w, input int a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a[ADDR_W-1:0]; cpu_wdata = d;
  endtask

  task automatic set_dma(input bit r, input bit w, input bit l, input int a, input logic [31:0] d);
    dma_req = r; dma_we = w; dma_last = l; dma_addr = a[ADDR_W-1:0]; dma_wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_gnt;
    reset = 1'b0;
    load_mem = 1'b1;
    set_cpu(1, 0, 5, 0);
    set_dma(1, 0, 0, 3, 0);

    // Reset: requests asserted but nothing may be granted.
    @(negedge clk);
    chk("reset_cpu_gnt", 32'(cpu_gnt), 0);
    chk("reset_dma_gnt", 32'(dma_gnt), 0);
    chk("reset_mem_en", 32'(mem_en), 0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    load_mem = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("init_stall_cnt", 32'(cpu_stall_cnt), 0);
    chk("init_state", 32'(dut.u_fsm.state_q), 0);
    next_cycle();

    // CPU-only read of address 5.
    set_cpu(1, 0, 5, 0);
    @(negedge clk);
    chk("cpu_rd_gnt", 32'(cpu_gnt), 1);
    chk("cpu_rd_mem_en", 32'(mem_en), 1);
    chk("cpu_rd_mem_addr", 32'(mem_addr), 5);
    chk("cpu_rd_rvalid_early", 32'(cpu_rvalid), 0);
    next_cycle();
    set_cpu(0, 0, 0, 0);
    @(negedge clk);
    chk("cpu_rd_rvalid", 32'(cpu_rvalid), 1);
    chk("cpu_rd_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_rd_dma_rvalid", 32'(dma_rvalid), 0);
    next_cycle();

    // Simultaneous requests from IDLE: CPU first, DMA once CPU drops.
    set_cpu(1, 1, 7, 32'h11112222);
    set_dma(1, 1, 1, 9, 32'h99990009);
    @(negedge clk);
    chk("sim_cpu_gnt", 32'(cpu_gnt), 1);
    chk("sim_dma_gnt", 32'(dma_gnt), 0);
    chk("sim_mem_wdata", mem_wdata, 32'h11112222);
    next_cycle();
    set_cpu(0, 0, 0, 0);
    @(negedge clk);
    chk("sim2_dma_gnt", 32'(dma_gnt), 1);
    chk("sim2_mem_addr", 32'(mem_addr), 9);
    next_cycle();
    set_dma(0, 0, 0, 0, 0);
    set_cpu(1, 0, 7, 0);
    @(negedge clk);
    chk("sim3_cpu_gnt", 32'(cpu_gnt), 1);
    next_cycle();
    set_cpu(0, 0, 0, 0);
    @(negedge clk);
    chk("sim3_rdata", cpu_rdata, 32'h11112222);
    next_cycle();

    // Starvation: CPU holds four cycles, DMA forced in on the fifth.
    for (int c = 1; c <= 8; c++) begin
      set_cpu(1, 1, 32 + c, 32'hC0000000 | 32'(c));
      set_dma(c <= 7, 1, c == 7, 48 + c, 32'hD0000000 | 32'(c));
      @(negedge clk);
      chk("starve_cpu_gnt", 32'(cpu_gnt), 32'(c <= 4 || c == 8));
      chk("starve_dma_gnt", 32'(dma_gnt), 32'(c >= 5 && c <= 7));
      chk("starve_stall_cnt", 32'(cpu_stall_cnt), (c <= 5) ? 0 : 32'(c - 5));
      next_cycle();
    end

    // Burst of 8 DMA writes; pending CPU request waits, then wins.
    n_gnt = 0;
    for (int c = 1; c <= 10; c++) begin
      set_cpu(c >= 2 && c <= 9, 1, 64 + c, 32'hE0000000 | 32'(c));
      set_dma(1, 1, c == 10, 16 + c - 1, 32'hB0000000 | 32'(c - 1));
      @(negedge clk);
      if (c <= 9 && dma_gnt) n_gnt++;
      if (c == 9) begin
        chk("burst_cpu_after", 32'(cpu_gnt), 1);
        chk("burst_dma_after", 32'(dma_gnt), 0);
        chk("burst_stall_cnt", 32'(cpu_stall_cnt), 10);
      end
      if (c == 10) chk("burst_new_tenure", 32'(dma_gnt), 1);
      next_cycle();
    end
    chk("burst_gnt_count", n_gnt, 8);

    // DMA read with dma_last on the first beat.
    set_cpu(0, 0, 0, 0);
    set_dma(1, 0, 1, 19, 0);
    @(negedge clk);
    chk("dma_rd_gnt", 32'(dma_gnt), 1);
    next_cycle();
    set_cpu(1, 0, 5, 0);
    set_dma(1, 0, 1, 19, 0);
    @(negedge clk);
    chk("dma_rd_rvalid", 32'(dma_rvalid), 1);
    chk("dma_rd_rdata", dma_rdata, 32'hB0000003);
    chk("dma_rd_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("dma_rd_tenure_end", 32'(cpu_gnt), 1);
    chk("dma_rd_no_dma_gnt", 32'(dma_gnt), 0);
    next_cycle();
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("dma_rd_cpu_data", cpu_rdata, 32'hDEADBEEF);
    next_cycle();

    // Reset asserted the cycle after a CPU read grant.
    set_cpu(1, 0, 5, 0);
    set_dma(1, 1, 0, 3, 1);
    @(negedge clk);
    chk("rst_rd_cpu_gnt", 32'(cpu_gnt), 1);
    next_cycle();
    reset = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_rd_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_rd_rdata", cpu_rdata, 0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_after_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_after_stall", 32'(cpu_stall_cnt), 0);
    chk("rst_after_starve", 32'(dut.u_fsm.starve_q), 0);
    chk("rst_after_burst", 32'(dut.u_fsm.burst_q), 0);
    chk("rst_after_state", 32'(dut.u_fsm.state_q), 0);
    next_cycle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
